// File: rtl/seg7_pkg.sv
// Shared constants and types for the 7-segment scan controller.
package seg7_pkg;

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam int NIB_W = 4;

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } scan_st_t;

endpackage

// File: rtl/seg7_scan_ctrl_if.sv
// Valid/ready write port carrying one nibble per digit.
interface seg7_scan_ctrl_if #(
    parameter int DIGITS = 4
);
    import seg7_pkg::*;

    logic                      wr_valid;
    logic                      wr_ready;
    logic [NIB_W*DIGITS-1:0]   wr_data;

    modport master (
        output wr_valid,
        output wr_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid,
        input  wr_data,
        output wr_ready
    );

endinterface

// File: rtl/seg7enc.sv
// Hex nibble to active-low segment pattern, bit 0 = segment a.
module seg7enc (
    input  logic [3:0] nib,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'h7F;
        case (nib)
            4'h0: seg = 7'h40;
            4'h1: seg = 7'h79;
            4'h2: seg = 7'h24;
            4'h3: seg = 7'h30;
            4'h4: seg = 7'h19;
            4'h5: seg = 7'h12;
            4'h6: seg = 7'h02;
            4'h7: seg = 7'h78;
            4'h8: seg = 7'h00;
            4'h9: seg = 7'h10;
            4'hA: seg = 7'h08;
            4'hB: seg = 7'h03;
            4'hC: seg = 7'h46;
            4'hD: seg = 7'h21;
            4'hE: seg = 7'h06;
            4'hF: seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
    end

endmodule

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan with blanking gap and frame-synchronous
// double-buffered display value.
module seg7_scan_ctrl
    import seg7_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 1024,
    parameter int BLANK    = 16
) (
    input  logic              clk,
    input  logic              rst,
    seg7_scan_ctrl_if.slave   wr,
    input  logic [DIGITS-1:0] blank_mask,
    output logic [6:0]        seg,
    output logic [DIGITS-1:0] dig_sel,
    output logic              frame_done
);

    localparam int SW     = $clog2(SCAN_DIV);
    localparam int DW     = $clog2(DIGITS);
    localparam int DATA_W = NIB_W * DIGITS;

    localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [SW-1:0] BLANK_LAST = SW'((BLANK > 0) ? BLANK - 1 : 0);
    localparam logic [DW-1:0] DIG_LAST   = DW'(DIGITS - 1);
    localparam scan_st_t      ST_INIT    = (BLANK > 0) ? ST_BLANK : ST_DRIVE;

    logic [SW-1:0]     slot_cnt;
    logic [DW-1:0]     dig;
    scan_st_t          state;
    scan_st_t          state_nxt;
    logic [DATA_W-1:0] disp;
    logic [DATA_W-1:0] pend;
    logic              pend_valid;
    logic              mask_q;
    logic              mask_eff;
    logic              slot_wrap;
    logic              frame_end;
    logic              accept;
    logic              drive;
    logic [NIB_W-1:0]  nib;
    logic [6:0]        enc;

    assign slot_wrap   = (slot_cnt == SLOT_LAST);
    assign frame_end   = slot_wrap && (dig == DIG_LAST);
    assign accept      = wr.wr_valid && !pend_valid;
    assign wr.wr_ready = !pend_valid;

    // Mask bit is live in the latch cycle itself so BLANK = 0 still honours it
    assign mask_eff = (slot_cnt == '0) ? blank_mask[dig] : mask_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt <= '0;
            dig      <= '0;
            state    <= ST_INIT;
            mask_q   <= 1'b0;
        end else begin
            slot_cnt <= slot_wrap ? '0 : slot_cnt + 1'b1;
            if (slot_wrap)
                dig <= (dig == DIG_LAST) ? '0 : dig + 1'b1;
            if (slot_cnt == '0)
                mask_q <= blank_mask[dig];
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        drive     = 1'b0;
        unique case (state)
            ST_BLANK: begin
                if (slot_cnt == BLANK_LAST)
                    state_nxt = ST_DRIVE;
            end
            ST_DRIVE: begin
                drive = !mask_eff;
                if (slot_wrap && (BLANK > 0))
                    state_nxt = ST_BLANK;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            disp       <= '0;
            pend       <= '0;
            pend_valid <= 1'b0;
        end else if (frame_end && pend_valid) begin
            disp       <= pend;
            pend_valid <= 1'b0;
        end else if (accept) begin
            pend       <= wr.wr_data;
            pend_valid <= 1'b1;
        end
    end

    always_comb begin
        nib = '0;
        for (int i = 0; i < DIGITS; i++)
            if (dig == DW'(i))
                nib = disp[NIB_W*i +: NIB_W];
    end

    seg7enc u_enc (
        .nib (nib),
        .seg (enc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            seg        <= SEG_OFF;
            dig_sel    <= '0;
            frame_done <= 1'b0;
        end else begin
            seg        <= drive ? enc : SEG_OFF;
            dig_sel    <= drive ? (DIGITS'(1) << dig) : '0;
            frame_done <= frame_end;
        end
    end

endmodule
